multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle main control FSM for the RV32I core; successor to the single-cycle control decode.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and handshakes with a shared wait-state memory.
//  Extends the ALU op set and adds timeout/illegal-op fault reporting. Sits between IR/ALU-flags and datapath.
// PARAMETERS
//  MAX_WAIT   16  max cycles a memory access may wait for mem_ready before timeout fault (>=1)
//  EN_SHIFTS  1   1: SLL/SRL/SRA decoded; 0: shift funct3 (001,101) flagged illegal
//  STATE_W    4   width of state debug output (>=4)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  run        in   1        level; 1 = execute instructions, 0 = stop at next instruction boundary
//  opcode     in   7        IR[6:0], stable from DECODE to end of instruction
//  funct3     in   3        IR[14:12]
//  funct7_5   in   1        IR[30]
//  zero       in   1        ALU zero flag
//  mem_ready  in   1        memory access complete this cycle
//  pc_write   out  1        load PC
//  pc_src     out  1        0 = ALU result, 1 = ALUOut register (branch target)
//  ir_write   out  1        load IR
//  iord       out  1        memory address: 0 = PC, 1 = ALUOut
//  mem_read   out  1        memory read request (held until mem_ready)
//  mem_write  out  1        memory write request (held until mem_ready)
//  reg_write  out  1        register file write
//  mem_to_reg out  1        writeback: 0 = ALUOut, 1 = MDR
//  alu_src_a  out  1        0 = PC, 1 = A reg
//  alu_src_b  out  2        0 = B reg, 1 = const 4, 2 = immediate
//  alu_sel    out  4        AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, SLTU 1011
//  busy       out  1        state != IDLE and != FAULT
//  illegal    out  1        sticky: unsupported instruction decoded
//  timeout    out  1        sticky: memory wait exceeded MAX_WAIT
//  state      out  STATE_W  current state encoding (debug)
// BEHAVIOUR
//  - Moore outputs decoded from registered state (+opcode/funct3/funct7_5 for alu_sel). Reset: state=IDLE, wait_cnt=0, illegal=timeout=0, all outputs 0.
//  - States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, FAULT.
//  - IDLE: run=1 -> FETCH. FETCH: mem_read, iord=0, src_a=0, src_b=1, ADD; on mem_ready ir_write=pc_write=1 (pc_src=0), -> DECODE.
//  - DECODE: src_a=0, src_b=2, ADD (branch target). opcode 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> MEM_ADDR;
//    1100011 with funct3=000 -> BRANCH; anything else (or shift funct3 when EN_SHIFTS=0) -> FAULT, illegal<=1.
//  - EXEC_R: src_a=1, src_b=0; EXEC_I: src_a=1, src_b=2; both -> WB_ALU. alu_sel from funct3: 000 ADD (SUB if R and funct7_5),
//    001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7_5), 110 OR, 111 AND.
//  - MEM_ADDR: src_a=1, src_b=2, ADD; -> MEM_RD (load) / MEM_WR (store). MEM_RD: mem_read, iord=1; on mem_ready -> WB_MEM.
//    MEM_WR: mem_write, iord=1; on mem_ready -> END. WB_ALU: reg_write, mem_to_reg=0. WB_MEM: reg_write, mem_to_reg=1.
//  - BRANCH: src_a=1, src_b=0, SUB; pc_write=zero, pc_src=1; -> END.
//  - END (leaving WB_ALU, WB_MEM, MEM_WR, BRANCH): run=1 -> FETCH, else IDLE. run only sampled in IDLE and at END.
//  - Wait counter: counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0; cleared on state change. When a cycle with
//    mem_ready=0 would make it reach MAX_WAIT -> FAULT, timeout<=1. mem_ready in the same cycle wins over timeout.
//  - FAULT: all strobes 0, absorbing; exit only via rst_n. illegal/timeout never both set.
//  - Latency with zero-wait memory (mem_ready=1 on first request cycle): R/I 4, LW 5, SW 4, BEQ 3 cycles.
//  - rst_n assertion mid-instruction: immediate return to reset values; no partial write strobes after deassertion.
// TESTING
//  - Reset then run=1, ADD x3 (0110011,000,f7_5=0), mem_ready=1 -> FETCH,DECODE,EXEC_R,WB_ALU; reg_write cycle 4; alu_sel 0010.
//  - SUB/SRA/SLTU/XOR R-types + ADDI/SRAI I-types -> alu_sel 0110/1010/1011/0011/0010/1010 in EXEC state.
//  - LW with mem_ready low 3 cycles in MEM_RD -> mem_read,iord=1 held 4 cycles, then WB_MEM mem_to_reg=1; total 8 cycles.
//  - BEQ zero=1 -> pc_write=1,pc_src=1 in BRANCH; zero=0 -> pc_write=0; run=0 at END -> IDLE, busy=0.
//  - mem_ready held 0 in FETCH, MAX_WAIT=16 -> FAULT with timeout=1 after 16 cycles; mem_ready=1 on 16th cycle -> DECODE, no fault.
//  - opcode 1111111 -> FAULT, illegal=1 sticky; EN_SHIFTS=0 + SLL -> FAULT; rst_n low mid-MEM_WR -> IDLE, mem_write=0 at once.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Handshake bundle between the multicycle control FSM and its datapath/memory side.
// Member suffixes are from the control block's point of view (_i into it, _o out of it).
interface multicycle_control_if #(
   parameter int STATE_W = 4
);
   logic               run_i;
   logic [6:0]         opcode_i;
   logic [2:0]         funct3_i;
   logic               funct7_5_i;
   logic               zero_i;
   logic               mem_ready_i;

   logic               pc_write_o;
   logic               pc_src_o;
   logic               ir_write_o;
   logic               iord_o;
   logic               mem_read_o;
   logic               mem_write_o;
   logic               reg_write_o;
   logic               mem_to_reg_o;
   logic               alu_src_a_o;
   logic [1:0]         alu_src_b_o;
   logic [3:0]         alu_sel_o;
   logic               busy_o;
   logic               illegal_o;
   logic               timeout_o;
   logic [STATE_W-1:0] state_o;

   modport master (
      output run_i, opcode_i, funct3_i, funct7_5_i, zero_i, mem_ready_i,
      input  pc_write_o, pc_src_o, ir_write_o, iord_o, mem_read_o, mem_write_o,
             reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_sel_o,
             busy_o, illegal_o, timeout_o, state_o
   );

   modport slave (
      input  run_i, opcode_i, funct3_i, funct7_5_i, zero_i, mem_ready_i,
      output pc_write_o, pc_src_o, ir_write_o, iord_o, mem_read_o, mem_write_o,
             reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_sel_o,
             busy_o, illegal_o, timeout_o, state_o
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control: sequences FETCH/DECODE/EXEC/MEM/WB against a wait-state memory
// and latches illegal-instruction / memory-timeout faults into an absorbing FAULT state.
module multicycle_control #(
   parameter int MAX_WAIT  = 16,
   parameter bit EN_SHIFTS = 1'b1,
   parameter int STATE_W   = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011, ALU_SUB  = 4'b0110, ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000, ALU_SRL  = 4'b1001, ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             illegal_q, illegal_d;
   logic             timeout_q, timeout_d;

   logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write;
   logic       reg_write, mem_to_reg, alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_sel, alu_funct;
   logic       is_shift, mem_wait;
   state_t     end_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
      end
   end

   // funct7_5 selects SUB only for register-register ops; ADDI ignores IR[30]
   always_comb begin
      alu_funct = ALU_ADD;
      case (bus.funct3_i)
         3'b000:  alu_funct = (state_q == S_EXEC_R && bus.funct7_5_i) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_funct = ALU_SLL;
         3'b010:  alu_funct = ALU_SLT;
         3'b011:  alu_funct = ALU_SLTU;
         3'b100:  alu_funct = ALU_XOR;
         3'b101:  alu_funct = bus.funct7_5_i ? ALU_SRA : ALU_SRL;
         3'b110:  alu_funct = ALU_OR;
         default: alu_funct = ALU_AND;
      endcase
   end

   assign is_shift  = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b101);
   assign mem_wait  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign end_state = bus.run_i ? S_FETCH : S_IDLE;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_sel    = ALU_AND;
      case (state_q)
         S_IDLE: if (bus.run_i) state_d = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            alu_sel   = ALU_ADD;
            if (bus.mem_ready_i) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'd2;
            alu_sel   = ALU_ADD;
            if ((bus.opcode_i == OP_R || bus.opcode_i == OP_I) && !EN_SHIFTS && is_shift) begin
               state_d   = S_FAULT;
               illegal_d = 1'b1;
            end else if (bus.opcode_i == OP_R) state_d = S_EXEC_R;
            else if (bus.opcode_i == OP_I) state_d = S_EXEC_I;
            else if (bus.opcode_i == OP_LD || bus.opcode_i == OP_ST) state_d = S_MEM_ADDR;
            else if (bus.opcode_i == OP_BR && bus.funct3_i == 3'b000) state_d = S_BRANCH;
            else begin
               state_d   = S_FAULT;
               illegal_d = 1'b1;
            end
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_sel   = alu_funct;
            state_d   = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_sel   = alu_funct;
            state_d   = S_WB_ALU;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_sel   = ALU_ADD;
            state_d   = (bus.opcode_i == OP_LD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (bus.mem_ready_i) state_d = S_WB_MEM;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (bus.mem_ready_i) state_d = end_state;
         end
         S_WB_ALU: begin
            reg_write = 1'b1;
            state_d   = end_state;
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = end_state;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_sel   = ALU_SUB;
            pc_src    = 1'b1;
            pc_write  = bus.zero_i;
            state_d   = end_state;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase

      // The wait that would reach MAX_WAIT faults instead; a ready in that same cycle never gets here
      if (mem_wait && !bus.mem_ready_i) begin
         if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            state_d   = S_FAULT;
            timeout_d = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end
      if (state_d != state_q) wait_cnt_d = '0;
   end

   assign bus.pc_write_o   = pc_write;
   assign bus.pc_src_o     = pc_src;
   assign bus.ir_write_o   = ir_write;
   assign bus.iord_o       = iord;
   assign bus.mem_read_o   = mem_read;
   assign bus.mem_write_o  = mem_write;
   assign bus.reg_write_o  = reg_write;
   assign bus.mem_to_reg_o = mem_to_reg;
   assign bus.alu_src_a_o  = alu_src_a;
   assign bus.alu_src_b_o  = alu_src_b;
   assign bus.alu_sel_o    = alu_sel;
   assign bus.busy_o       = (state_q != S_IDLE) && (state_q != S_FAULT);
   assign bus.illegal_o    = illegal_q;
   assign bus.timeout_o    = timeout_q;
   assign bus.state_o      = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle plans derived from the phase rules, random
// instruction mix with random memory waits, plus directed fault/reset cases on two parameterisations.
module tb_multicycle_control;
   localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_XOR = 4'b0011;
   localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_SLL = 4'b1000, A_SRL = 4'b1001;
   localparam logic [3:0] A_SRA = 4'b1010, A_SLTU = 4'b1011;
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

   typedef struct packed {
      logic       pc_write;
      logic       pc_src;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_sel;
      logic       busy;
   } ctl_t;

   typedef struct packed {
      logic mr;
      ctl_t exp;
      ctl_t care;
   } step_t;

   logic  clk = 1'b0;
   logic  rst_n;
   int    n_cmp = 0;
   int    n_err = 0;
   step_t steps[$];

   always #5 clk = ~clk;

   multicycle_control_if #(.STATE_W(4)) ifa ();
   multicycle_control_if #(.STATE_W(4)) ifb ();

   assign ifb.run_i       = ifa.run_i;
   assign ifb.opcode_i    = ifa.opcode_i;
   assign ifb.funct3_i    = ifa.funct3_i;
   assign ifb.funct7_5_i  = ifa.funct7_5_i;
   assign ifb.zero_i      = ifa.zero_i;
   assign ifb.mem_ready_i = ifa.mem_ready_i;

   multicycle_control #(.MAX_WAIT(16), .EN_SHIFTS(1'b1), .STATE_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   multicycle_control #(.MAX_WAIT(3), .EN_SHIFTS(1'b0), .STATE_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   function automatic ctl_t obs_a();
      return {ifa.pc_write_o, ifa.pc_src_o, ifa.ir_write_o, ifa.iord_o, ifa.mem_read_o,
              ifa.mem_write_o, ifa.reg_write_o, ifa.mem_to_reg_o, ifa.alu_src_a_o,
              ifa.alu_src_b_o, ifa.alu_sel_o, ifa.busy_o};
   endfunction

   function automatic ctl_t strb();
      ctl_t c = '0;
      c.pc_write = 1'b1; c.ir_write = 1'b1; c.mem_read = 1'b1;
      c.mem_write = 1'b1; c.reg_write = 1'b1; c.busy = 1'b1;
      return c;
   endfunction

   function automatic ctl_t alu_care(input ctl_t c_in);
      ctl_t c = c_in;
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_sel = 4'b1111;
      return c;
   endfunction

   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f75, input logic is_r);
      case (f3)
         3'd0: return (is_r && f75) ? A_SUB : A_ADD;
         3'd1: return A_SLL;
         3'd2: return A_SLT;
         3'd3: return A_SLTU;
         3'd4: return A_XOR;
         3'd5: return f75 ? A_SRA : A_SRL;
         3'd6: return A_OR;
         default: return A_AND;
      endcase
   endfunction

   task automatic chk_ctl(input string tag, input ctl_t o, input ctl_t e, input ctl_t c);
      n_cmp++;
      assert ((o & c) === (e & c)) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, o & c, e & c);
      end
   endtask

   task automatic chk_val(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, o, e);
      end
   endtask

   task automatic push(input logic mr, input ctl_t e, input ctl_t c);
      step_t s;
      s.mr = mr; s.exp = e; s.care = c;
      steps.push_back(s);
   endtask

   // Expected per-cycle outputs of one instruction; fw/mw are memory wait cycles before ready.
   task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic zf, input int fw, input int mw);
      ctl_t e, c;
      steps.delete();
      for (int k = 0; k <= fw; k++) begin
         e = '0; c = alu_care(strb()); c.iord = 1'b1; c.pc_src = 1'b1;
         e.busy = 1'b1; e.mem_read = 1'b1; e.alu_src_b = 2'd1; e.alu_sel = A_ADD;
         e.ir_write = (k == fw); e.pc_write = (k == fw);
         push(k == fw, e, c);
      end
      e = '0; c = alu_care(strb());
      e.busy = 1'b1; e.alu_src_b = 2'd2; e.alu_sel = A_ADD;
      push(1'($urandom_range(0, 1)), e, c);
      if (op == OP_R || op == OP_I) begin
         e = '0; c = alu_care(strb());
         e.busy = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = (op == OP_R) ? 2'd0 : 2'd2;
         e.alu_sel = alu_of(f3, f75, op == OP_R);
         push(1'($urandom_range(0, 1)), e, c);
         e = '0; c = strb(); c.mem_to_reg = 1'b1;
         e.busy = 1'b1; e.reg_write = 1'b1;
         push(1'($urandom_range(0, 1)), e, c);
      end else if (op == OP_LD || op == OP_ST) begin
         e = '0; c = alu_care(strb());
         e.busy = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_sel = A_ADD;
         push(1'($urandom_range(0, 1)), e, c);
         for (int k = 0; k <= mw; k++) begin
            e = '0; c = strb(); c.iord = 1'b1;
            e.busy = 1'b1; e.iord = 1'b1; e.mem_read = (op == OP_LD); e.mem_write = (op == OP_ST);
            push(k == mw, e, c);
         end
         if (op == OP_LD) begin
            e = '0; c = strb(); c.mem_to_reg = 1'b1;
            e.busy = 1'b1; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            push(1'($urandom_range(0, 1)), e, c);
         end
      end else if (op == OP_BR && f3 == 3'd0) begin
         e = '0; c = alu_care(strb()); c.pc_src = 1'b1;
         e.busy = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'd0; e.alu_sel = A_SUB;
         e.pc_src = 1'b1; e.pc_write = zf;
         push(1'($urandom_range(0, 1)), e, c);
      end
   endtask

   task automatic exec_steps(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input logic zf, input int nmax, input logic stop);
      int n;
      n = (nmax < 0 || nmax > steps.size()) ? steps.size() : nmax;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin
            ifa.opcode_i = op; ifa.funct3_i = f3; ifa.funct7_5_i = f75; ifa.zero_i = zf;
         end
         ifa.mem_ready_i = steps[i].mr;
         ifa.run_i       = !(stop && i == n - 1);
         #1;
         chk_ctl($sformatf("%s.cyc%0d", tag, i + 1), obs_a(), steps[i].exp, steps[i].care);
         chk_val($sformatf("%s.flags%0d", tag, i + 1), {30'd0, ifa.illegal_o, ifa.timeout_o}, 32'd0);
      end
      $display("instr %-8s op=%b f3=%b f7_5=%b zero=%b cycles=%0d stop=%b", tag, op, f3, f75, zf, n, stop);
   endtask

   task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic f75, input logic zf, input int fw, input int mw,
                            input logic stop);
      plan_instr(op, f3, f75, zf, fw, mw);
      exec_steps(tag, op, f3, f75, zf, -1, stop);
   endtask

   task automatic idle_cycle(input string tag);
      @(negedge clk);
      ifa.run_i = 1'b1;
      ifa.mem_ready_i = 1'($urandom_range(0, 1));
      #1;
      chk_ctl(tag, obs_a(), '0, '1);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0; ifa.run_i = 1'b0; ifa.mem_ready_i = 1'b0;
      #1;
      chk_ctl({tag, ".outs"}, obs_a(), '0, '1);
      chk_val({tag, ".flags"}, {30'd0, ifa.illegal_o, ifa.timeout_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic fault_hold(input string tag, input logic ill, input logic tmo, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ifa.run_i = 1'b1;
         ifa.mem_ready_i = 1'($urandom_range(0, 1));
         #1;
         chk_ctl($sformatf("%s.outs%0d", tag, i), obs_a(), '0, '1);
         chk_val($sformatf("%s.flags%0d", tag, i), {30'd0, ifa.illegal_o, ifa.timeout_o}, {30'd0, ill, tmo});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] ops[5];
      logic [6:0] op;
      logic [2:0] f3;
      logic       stop;
      int         fw;
      ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST; ops[4] = OP_BR;
      rst_n = 1'b0;
      ifa.run_i = 1'b0; ifa.opcode_i = '0; ifa.funct3_i = '0; ifa.funct7_5_i = 1'b0;
      ifa.zero_i = 1'b0; ifa.mem_ready_i = 1'b0;
      repeat (2) @(negedge clk);

      do_reset("rst0");
      idle_cycle("idle0");
      run_instr("add", OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
      run_instr("sub", OP_R, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
      run_instr("sra", OP_R, 3'b101, 1'b1, 1'b0, 0, 0, 1'b0);
      run_instr("sltu", OP_R, 3'b011, 1'b0, 1'b0, 0, 0, 1'b0);
      run_instr("xor", OP_R, 3'b100, 1'b0, 1'b0, 0, 0, 1'b0);
      run_instr("addi", OP_I, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
      run_instr("srai", OP_I, 3'b101, 1'b1, 1'b0, 0, 0, 1'b0);
      run_instr("lw_w3", OP_LD, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0);
      run_instr("sw", OP_ST, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
      run_instr("beq_t", OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0);
      run_instr("beq_nt", OP_BR, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1);
      idle_cycle("idle_after_beq");
      run_instr("fetch15", OP_R, 3'b110, 1'b0, 1'b0, 15, 0, 1'b0);

      for (int t = 0; t < 30; t++) begin
         op   = ops[$urandom_range(0, 4)];
         f3   = 3'($urandom_range(0, 7));
         if (op == OP_BR) f3 = 3'd0;
         fw   = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
         stop = ($urandom_range(0, 3) == 0);
         run_instr($sformatf("rnd%0d", t), op, f3, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), fw, int'($urandom_range(0, 5)), stop);
         if (stop) idle_cycle($sformatf("rnd%0d.idle", t));
      end

      do_reset("rst_to");
      idle_cycle("idle_to");
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         ifa.mem_ready_i = 1'b0;
         #1;
         chk_val($sformatf("to.fetch%0d", k), {29'd0, ifa.mem_read_o, ifa.busy_o, ifa.ir_write_o}, 32'd6);
      end
      fault_hold("to.fault", 1'b0, 1'b1, 3);

      do_reset("rst_ill");
      idle_cycle("idle_ill");
      run_instr("bad_op", OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
      fault_hold("ill.fault", 1'b1, 1'b0, 3);

      do_reset("rst_sll");
      idle_cycle("idle_sll");
      run_instr("sll", OP_R, 3'b001, 1'b0, 1'b0, 0, 0, 1'b0);
      chk_val("b.sll_illegal", {29'd0, ifb.illegal_o, ifb.timeout_o, ifb.busy_o}, 32'd4);

      do_reset("rst_w2");
      idle_cycle("idle_w2");
      run_instr("b_wait2", OP_I, 3'b000, 1'b0, 1'b0, 2, 0, 1'b0);
      chk_val("b.wait2_ok", {29'd0, ifb.illegal_o, ifb.timeout_o, ifb.busy_o}, 32'd1);

      do_reset("rst_w3");
      idle_cycle("idle_w3");
      run_instr("b_wait3", OP_I, 3'b000, 1'b0, 1'b0, 3, 0, 1'b0);
      chk_val("b.wait3_timeout", {29'd0, ifb.illegal_o, ifb.timeout_o, ifb.busy_o}, 32'd2);

      do_reset("rst_sw");
      idle_cycle("idle_sw");
      plan_instr(OP_ST, 3'b010, 1'b0, 1'b0, 0, 5);
      exec_steps("sw_cut", OP_ST, 3'b010, 1'b0, 1'b0, 4, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_val("sw_cut.mem_write", {31'd0, ifa.mem_write_o}, 32'd0);
      chk_ctl("sw_cut.outs", obs_a(), '0, '1);
      @(negedge clk);
      rst_n = 1'b1;
      ifa.run_i = 1'b0;
      idle_cycle("idle_recover");
      run_instr("add_rec", OP_R, 3'b000, 1'b0, 1'b0, 1, 0, 1'b1);
      idle_cycle("idle_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
